// File: rtl/decode_stage.sv
// decode_stage: registered ID stage of the RV32I core.
// Splits the instruction into fields, builds the sign-extended immediate and
// flags illegal encodings on the input side. The result is held in an output
// register, plus an optional skid register that lets in_ready come from a flop.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. A producer holds valid and its payload steady until that edge. This
// stage never withdraws out_valid and never changes out_* while
// out_valid & !out_ready, unless flush or reset intervenes.
module decode_stage #(
  parameter int XLEN = 32,  // must be >= 32
  parameter int PC_W = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_opcode,
  output logic [2:0]      out_func3,
  output logic [6:0]      out_func7,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [PC_W-1:0] out_pc,
  output logic            out_illegal
);

  // inst[1:0] is only needed for the legality check, so it is not stored.
  logic [31:2]     out_inst_q;
  logic [XLEN-1:0] out_imm_q;
  logic [PC_W-1:0] out_pc_q;
  logic            out_ill_q;
  logic            out_valid_q;

  logic [31:2]     skid_inst_q;
  logic [XLEN-1:0] skid_imm_q;
  logic [PC_W-1:0] skid_pc_q;
  logic            skid_ill_q;
  logic            skid_valid_q;

  logic            in_ready_q;

  logic [31:0]     dec_imm32;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;

  logic            in_fire;
  logic            out_valid_d;
  logic            skid_valid_d;
  logic            load_out;
  logic            load_from_skid;
  logic            load_skid;

  // Immediate generation and legality check from the incoming instruction.
  always_comb begin
    dec_imm32   = 32'h0;
    dec_illegal = 1'b0;
    case (in_inst[6:2])
      5'b00000, 5'b00100, 5'b11001, 5'b00011, 5'b11100:
        dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      5'b01000:
        dec_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      5'b11000:
        dec_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                     in_inst[30:25], in_inst[11:8], 1'b0};
      5'b01101, 5'b00101:
        dec_imm32 = {in_inst[31:12], 12'h000};
      5'b11011:
        dec_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                     in_inst[20], in_inst[30:21], 1'b0};
      5'b01100:
        dec_imm32 = 32'h0;
      default:
        dec_illegal = 1'b1;
    endcase
    if (in_inst[1:0] != 2'b11) begin
      dec_illegal = 1'b1;
    end
    if (dec_illegal) begin
      dec_imm32 = 32'h0;
    end
    // Sign-extend the 32-bit immediate up to XLEN.
    dec_imm       = {XLEN{dec_imm32[31]}};
    dec_imm[31:0] = dec_imm32;
  end

  assign in_ready = (SKID != 0) ? in_ready_q : (!out_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;

  // Buffer control: where an accepted entry goes and what drains.
  always_comb begin
    out_valid_d    = out_valid_q;
    skid_valid_d   = skid_valid_q;
    load_out       = 1'b0;
    load_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (SKID != 0) begin
      if (!out_valid_q || out_ready) begin
        // Output register is empty or draining this cycle.
        if (skid_valid_q) begin
          load_out       = 1'b1;
          load_from_skid = 1'b1;
          out_valid_d    = 1'b1;
          skid_valid_d   = 1'b0;
        end else if (in_fire) begin
          load_out    = 1'b1;
          out_valid_d = 1'b1;
        end else begin
          out_valid_d = 1'b0;
        end
      end else if (in_fire) begin
        // Output stalled: park the new entry in the skid register.
        load_skid    = 1'b1;
        skid_valid_d = 1'b1;
      end
    end else begin
      if (in_fire) begin
        load_out    = 1'b1;
        out_valid_d = 1'b1;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Valid flags and the registered in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
    end
  end

  // Output payload register: loads from the skid entry or the decoder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_inst_q <= '0;
      out_imm_q  <= '0;
      out_pc_q   <= '0;
      out_ill_q  <= 1'b0;
    end else if (load_out) begin
      if (load_from_skid) begin
        out_inst_q <= skid_inst_q;
        out_imm_q  <= skid_imm_q;
        out_pc_q   <= skid_pc_q;
        out_ill_q  <= skid_ill_q;
      end else begin
        out_inst_q <= in_inst[31:2];
        out_imm_q  <= dec_imm;
        out_pc_q   <= in_pc;
        out_ill_q  <= dec_illegal;
      end
    end
  end

  // Skid payload register: captures an entry accepted during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_inst_q <= '0;
      skid_imm_q  <= '0;
      skid_pc_q   <= '0;
      skid_ill_q  <= 1'b0;
    end else if (load_skid) begin
      skid_inst_q <= in_inst[31:2];
      skid_imm_q  <= dec_imm;
      skid_pc_q   <= in_pc;
      skid_ill_q  <= dec_illegal;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_opcode  = out_inst_q[6:2];
  assign out_func3   = out_inst_q[14:12];
  assign out_func7   = out_inst_q[31:25];
  assign out_rs1     = out_inst_q[19:15];
  assign out_rs2     = out_inst_q[24:20];
  assign out_rd      = out_inst_q[11:7];
  assign out_imm     = out_imm_q;
  assign out_pc      = out_pc_q;
  assign out_illegal = out_ill_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed bench for decode_stage (SKID=1, XLEN=32) with a
// second XLEN=64, SKID=0 instance sharing the same input stream.
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_opcode;
  logic [2:0]  out_func3;
  logic [6:0]  out_func7;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [31:0] out_imm;
  logic [31:0] out_pc;
  logic        out_illegal;

  logic        o64_in_ready;
  logic        o64_valid;
  logic [4:0]  o64_opcode;
  logic [2:0]  o64_func3;
  logic [6:0]  o64_func7;
  logic [4:0]  o64_rs1;
  logic [4:0]  o64_rs2;
  logic [4:0]  o64_rd;
  logic [63:0] o64_imm;
  logic [31:0] o64_pc;
  logic        o64_illegal;

  int total;
  int bad;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  op;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  decode_stage #(.XLEN(32), .PC_W(32), .SKID(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_func3(out_func3), .out_func7(out_func7),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_pc(out_pc), .out_illegal(out_illegal)
  );

  decode_stage #(.XLEN(64), .PC_W(32), .SKID(0)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(o64_in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(o64_valid), .out_ready(out_ready),
    .out_opcode(o64_opcode), .out_func3(o64_func3), .out_func7(o64_func7),
    .out_rs1(o64_rs1), .out_rs2(o64_rs2), .out_rd(o64_rd),
    .out_imm(o64_imm), .out_pc(o64_pc), .out_illegal(o64_illegal)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present one instruction at the next falling edge.
  task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
    @(negedge clk);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
  endtask

  task automatic test_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if ({out_opcode, out_func3, out_func7, out_rs1, out_rs2, out_rd} !== 30'h0) begin
      bad++; $display("FAIL reset_fields: got %h want 0", {out_opcode, out_func3, out_func7, out_rs1, out_rs2, out_rd}); end
    total++; if (out_imm !== 32'h0 || out_pc !== 32'h0 || out_illegal !== 1'b0) begin
      bad++; $display("FAIL reset_imm_pc: got imm=%h pc=%h ill=%b want 0", out_imm, out_pc, out_illegal); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Back-to-back stream of decodes with out_ready held high.
  task automatic test_decode();
    vec_t v[16];
    logic [63:0] e64;
    v[0]  = '{32'hFFF00093, 5'h04, 5'd1,  32'hFFFFFFFF, 1'b0};
    v[1]  = '{32'hFE000EE3, 5'h18, 5'h1D, 32'hFFFFFFFC, 1'b0};
    v[2]  = '{32'h123452B7, 5'h0D, 5'd5,  32'h12345000, 1'b0};
    v[3]  = '{32'hFFFFF197, 5'h05, 5'd3,  32'hFFFFF000, 1'b0};
    v[4]  = '{32'hFE20AFA3, 5'h08, 5'h1F, 32'hFFFFFFFF, 1'b0};
    v[5]  = '{32'h0020A423, 5'h08, 5'd8,  32'h00000008, 1'b0};
    v[6]  = '{32'h0010006F, 5'h1B, 5'd0,  32'h00000800, 1'b0};
    v[7]  = '{32'h8000006F, 5'h1B, 5'd0,  32'hFFF00000, 1'b0};
    v[8]  = '{32'h402081B3, 5'h0C, 5'd3,  32'h00000000, 1'b0};
    v[9]  = '{32'h00000000, 5'h00, 5'd0,  32'h00000000, 1'b1};
    v[10] = '{32'h0000007F, 5'h1F, 5'd0,  32'h00000000, 1'b1};
    v[11] = '{32'h8000A103, 5'h00, 5'd2,  32'hFFFFF800, 1'b0};
    v[12] = '{32'h0FF0000F, 5'h03, 5'd0,  32'h000000FF, 1'b0};
    v[13] = '{32'h00000073, 5'h1C, 5'd0,  32'h00000000, 1'b0};
    v[14] = '{32'h00008067, 5'h19, 5'd0,  32'h00000000, 1'b0};
    v[15] = '{32'h00000091, 5'h04, 5'd1,  32'h00000000, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(v[i].inst, 32'h100 + 32'(i) * 4);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL dec_in_ready[%0d]: got %b want 1", i, in_ready); end
      @(posedge clk);
      #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL dec_valid[%0d]: got %b want 1", i, out_valid); end
      total++; if (out_opcode !== v[i].op) begin bad++; $display("FAIL dec_opcode[%0d]: got %h want %h", i, out_opcode, v[i].op); end
      total++; if (out_rd !== v[i].rd) begin bad++; $display("FAIL dec_rd[%0d]: got %h want %h", i, out_rd, v[i].rd); end
      total++; if (out_imm !== v[i].imm) begin bad++; $display("FAIL dec_imm[%0d]: got %h want %h", i, out_imm, v[i].imm); end
      total++; if (out_illegal !== v[i].ill) begin bad++; $display("FAIL dec_illegal[%0d]: got %b want %b", i, out_illegal, v[i].ill); end
      total++; if (out_pc !== 32'h100 + 32'(i) * 4) begin bad++; $display("FAIL dec_pc[%0d]: got %h want %h", i, out_pc, 32'h100 + 32'(i) * 4); end
      e64 = {{32{v[i].imm[31]}}, v[i].imm};
      total++; if (o64_imm !== e64) begin bad++; $display("FAIL dec_imm64[%0d]: got %h want %h", i, o64_imm, e64); end
      if (i == 8) begin
        total++; if (out_func7 !== 7'h20 || out_func3 !== 3'h0 || out_rs1 !== 5'd1 || out_rs2 !== 5'd2) begin
          bad++; $display("FAIL dec_sub_fields: got f7=%h f3=%h rs1=%0d rs2=%0d want 20 0 1 2", out_func7, out_func3, out_rs1, out_rs2); end
      end
      if (i == 0) begin
        total++; if (out_rs1 !== 5'd0 || out_func3 !== 3'h0) begin
          bad++; $display("FAIL dec_addi_fields: got rs1=%0d f3=%h want 0 0", out_rs1, out_func3); end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dec_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    int first;
    int last;
    logic acc;
    logic [31:0] exp_pc;
    exp_q.delete();
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    exp_q.push_back(32'h208);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1; in_inst = 32'h00100093; in_pc = 32'h200;
    @(posedge clk);
    drive(32'h00200113, 32'h204);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_b: got %b want 1", in_ready); end
    @(posedge clk);
    drive(32'h00300193, 32'h208);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full: got %b want 0", in_ready); end
    total++; if (out_pc !== 32'h200) begin bad++; $display("FAIL bp_head: got %h want 200", out_pc); end
    @(posedge clk);
    @(negedge clk);
    total++; if (in_ready !== 1'b0 || out_pc !== 32'h200 || out_imm !== 32'h1) begin
      bad++; $display("FAIL bp_stable: got ready=%b pc=%h imm=%h want 0 200 1", in_ready, out_pc, out_imm); end
    out_ready = 1'b1;
    acc = 1'b0; first = -1; last = -1;
    for (int cyc = 0; cyc < 10 && exp_q.size() > 0; cyc++) begin
      if (out_valid && out_ready) begin
        exp_pc = exp_q.pop_front();
        total++; if (out_pc !== exp_pc) begin bad++; $display("FAIL bp_order: got %h want %h", out_pc, exp_pc); end
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (in_valid && in_ready) acc = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (acc) in_valid = 1'b0;
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bp_timeout: got %0d left want 0", exp_q.size()); end
    total++; if (last - first != 2) begin bad++; $display("FAIL bp_consecutive: got span %0d want 2", last - first); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup: got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1; in_inst = 32'h00100093; in_pc = 32'h300;
    @(posedge clk);
    drive(32'h00200113, 32'h304);
    @(posedge clk);
    drive(32'h00300193, 32'h308);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fl_full: got %b want 0", in_ready); end
    flush = 1'b1;
    @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL fl_squash: got valid=%b ready=%b want 0 1", out_valid, in_ready); end
    // Flush while in_ready is high: the concurrent handshake is dropped.
    @(negedge clk);
    flush = 1'b0;
    in_inst = 32'h00400213; in_pc = 32'h30C;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    in_inst = 32'h00500293; in_pc = 32'h310;
    total++; if (in_ready !== 1'b1 || out_pc !== 32'h30C) begin
      bad++; $display("FAIL fl_pre: got ready=%b pc=%h want 1 30c", in_ready, out_pc); end
    @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_drop_in: got %b want 0", out_valid); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_no_deliver: got %b want 0", out_valid); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1; in_inst = 32'hFFF00093; in_pc = 32'h400;
    @(posedge clk);
    drive(32'h123452B7, 32'h404);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0 || out_imm !== 32'hFFFFFFFF) begin
      bad++; $display("FAIL ar_pre: got ready=%b imm=%h want 0 ffffffff", in_ready, out_imm); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL ar_ctrl: got valid=%b ready=%b want 0 1", out_valid, in_ready); end
    total++; if (out_imm !== 32'h0 || out_pc !== 32'h0 || out_rd !== 5'd0 || out_opcode !== 5'd0) begin
      bad++; $display("FAIL ar_data: got imm=%h pc=%h rd=%h op=%h want 0", out_imm, out_pc, out_rd, out_opcode); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(32'h123452B7, 32'h500);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_empty: got %b want 0", out_valid); end
    @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b1 || out_imm !== 32'h12345000 || out_rd !== 5'd5 || out_pc !== 32'h500) begin
      bad++; $display("FAIL ar_first: got v=%b imm=%h rd=%0d pc=%h want 1 12345000 5 500", out_valid, out_imm, out_rd, out_pc); end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
  endtask

  // The SKID=0 instance drives in_ready combinationally from out_ready.
  task automatic test_skid0();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1; in_inst = 32'hFE000EE3; in_pc = 32'h600;
    @(posedge clk);
    #1;
    total++; if (o64_valid !== 1'b1 || o64_pc !== 32'h600 || o64_imm !== 64'hFFFFFFFFFFFFFFFC) begin
      bad++; $display("FAIL s0_load: got v=%b pc=%h imm=%h want 1 600 fffffffffffffffc", o64_valid, o64_pc, o64_imm); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++; if (o64_in_ready !== 1'b0) begin bad++; $display("FAIL s0_stall: got %b want 0", o64_in_ready); end
    out_ready = 1'b1;
    #1;
    total++; if (o64_in_ready !== 1'b1) begin bad++; $display("FAIL s0_comb: got %b want 1", o64_in_ready); end
    @(posedge clk);
    @(posedge clk);
    #1;
    total++; if (o64_valid !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL s0_drain: got %b %b want 0 0", o64_valid, out_valid); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_inst = 32'h0;
    in_pc = 32'h0;
    out_ready = 1'b0;
    test_reset();
    test_decode();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_skid0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
